// File: rtl/mul4b_seq_pkg.sv
// Shared constants and types for the 4x4 sequential shift-add multiplier.
//   OP_W   : operand width (a, b, mcand, acc halves)
//   PROD_W : product width
//   STEPS  : number of shift-add steps per multiplication
//   CNT_W  : width of the step counter
//   state_t: FSM state encoding
package mul4b_seq_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int STEPS  = 4;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul4b_seq_sum4b.sv
// 4-bit ripple-carry adder stage.
// Ports:
//   a, b : 4-bit addends
//   ci   : carry in
//   so   : 4-bit sum
//   co   : carry out
module sum4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic       co,
  output logic [3:0] so
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign so[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign co = c[4];

endmodule

// File: rtl/mul4b_seq.sv
// Unsigned 4x4 sequential shift-add multiplier, one partial product per cycle.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, sampled only in IDLE together with a and b
//   a, b  : unsigned multiplicand / multiplier
//   busy  : high in CALC and DONE
//   done  : one-cycle pulse, p is final in that cycle
//   p     : registered product, held until the next completion
//
// state | meaning
// IDLE  | waiting for start
// CALC  | four shift-add steps, one per cycle
// DONE  | product published, done pulsed; returns to IDLE unconditionally
module mul4b_seq
  import mul4b_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] p
);

  state_t state, state_nxt;

  logic [OP_W-1:0]   mcand;
  logic [OP_W-1:0]   acc_hi;
  logic [OP_W-1:0]   acc_lo;
  logic [CNT_W-1:0]  cnt;

  logic [OP_W-1:0]   addend;
  logic [OP_W-1:0]   sum;
  logic              co;
  logic              last_step;
  logic [PROD_W-1:0] acc_nxt;

  // Partial product selected by the current multiplier LSB, which sits in acc_lo[0].
  assign addend = acc_lo[0] ? mcand : '0;

  sum4b u_sum4b (
    .a  (acc_hi),
    .b  (addend),
    .ci (1'b0),
    .co (co),
    .so (sum)
  );

  // Carry becomes the new MSB so no bit of the partial sum is lost on the shift.
  assign acc_nxt   = {co, sum, acc_lo[OP_W-1:1]};
  assign last_step = (cnt == CNT_W'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC) || (state == DONE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      p      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            acc_lo <= b;
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          {acc_hi, acc_lo} <= acc_nxt;
          cnt              <= cnt + CNT_W'(1);
          if (last_step) begin
            p <= acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul4b_seq.sv
module tb_mul4b_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] p;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] p_model = 8'h00;

  always #5 clk = ~clk;

  mul4b_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full multiplication. noise drives random start/a/b while busy;
  // force_at >= 0 drives a deliberate start with F*F in that busy cycle.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb,
                        input bit noise, input int force_at);
    logic [7:0] exp_p;
    int busy_cnt;
    exp_p    = 8'(ta) * 8'(tb);
    busy_cnt = 0;
    a = ta; b = tb; start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      a = 4'($urandom); b = 4'($urandom);
      if (i == force_at) begin
        start = 1'b1; a = 4'hF; b = 4'hF;
      end
      chk("busy_calc", busy, 1);
      chk("done_calc", done, 0);
      chk("p_hold_calc", p, p_model);
      busy_cnt += int'(busy);
      tick();
    end
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("product", p, exp_p);
    busy_cnt += int'(busy);
    p_model = exp_p;
    start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    chk("done_after", done, 0);
    chk("busy_after", busy, 0);
    chk("p_hold_idle", p, p_model);
    chk("busy_cycles", busy_cnt, 5);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick();
    start = 1'b1; a = 4'h5; b = 4'h5;
    tick();
    chk("rst_p", p, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0; start = 1'b0;

    run_op(4'hF, 4'hF, 1'b0, -1);
    run_op(4'hA, 4'h3, 1'b0, -1);
    run_op(4'h7, 4'h9, 1'b0, -1);
    run_op(4'h0, 4'hF, 1'b0, -1);
    run_op(4'h3, 4'h5, 1'b0, 1);

    // Reset during the second CALC cycle discards the operation.
    a = 4'hF; b = 4'hF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p_model = 8'h00;
    chk("midrst_p", p, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_done", done, 0);
      chk("midrst_p_hold", p, 0);
    end
    run_op(4'h2, 4'h3, 1'b0, -1);

    // Start held high: one product every 6 cycles.
    a = 4'h4; b = 4'h4; start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      chk("b2b_done", done, ((i % 6) == 4) ? 1 : 0);
      chk("b2b_busy", busy, ((i % 6) == 5) ? 0 : 1);
      if ((i % 6) == 4) p_model = 8'h10;
      chk("b2b_p", p, p_model);
    end
    start = 1'b0;
    tick();

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run_op(4'(x), 4'(y), 1'b1, -1);
      end
    end

    for (int n = 0; n < 64; n++) begin
      run_op(4'($urandom), 4'($urandom), 1'b1, -1);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul4b_seq.md
MUL4B_SEQ -- requirements
Module: mul4b_seq

Interface
REQ-001 Parameters: none; the operand width is fixed at 4 bits to match the sum4b adder stage it instantiates.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst  input  1  Reset, synchronous, active-high.
REQ-004 start  input  1  Request to multiply; sampled only in state IDLE.
REQ-005 a  input  4  Multiplicand, unsigned; sampled with start.
REQ-006 b  input  4  Multiplier, unsigned; sampled with start.
REQ-007 busy  output  1  High while a multiplication is in progress (states CALC and DONE).
REQ-008 done  output  1  One-cycle pulse; p is valid and final in that cycle.
REQ-009 p  output  8  Product a*b, unsigned, registered.

Function
REQ-010 The block SHALL implement an unsigned 4x4 shift-add multiplier with FSM states IDLE, CALC and DONE.
- Registers: mcand[3:0], acc_hi[3:0], acc_lo[3:0] (initially the multiplier), and a 2-bit step counter.
REQ-011 In IDLE with start=1 at edge k, the block SHALL:
- latch mcand=a and acc_lo=b;
- clear acc_hi and the counter;
- enter CALC.
REQ-012 Each CALC cycle SHALL compute {co,so} = acc_hi + (acc_lo[0] ? mcand : 4'h0) through one sum4b instance with ci=0.
- At the edge, load {acc_hi,acc_lo} <= {co,so,acc_lo[3:1]}.
- Increment the counter.
REQ-013 CALC SHALL last exactly 4 cycles (edges k+1..k+4).
- At edge k+4: p <= {acc_hi,acc_lo} after the 4th step, and the FSM enters DONE.
REQ-014 done SHALL be 1 only in the DONE cycle (the cycle following edge k+4); DONE SHALL return to IDLE unconditionally on the next edge.
REQ-015 Latency: the start-sampling edge k to the done cycle is exactly 4 cycles; the throughput is one product per 6 cycles when start is held high.
REQ-016 p SHALL hold its value from completion until the next completion.
- p SHALL NOT change during CALC.
REQ-017 start SHALL be ignored in CALC and DONE.
- No queuing: a start in those states has no effect.
- Inputs a and b are don't-care outside IDLE.
REQ-018 start held high continuously SHALL restart the operation on the first IDLE cycle after DONE, re-sampling a and b.
REQ-019 Arithmetic: the 8-bit product SHALL never overflow (max 15*15=225).
- The sum4b carry-out SHALL be captured every step, never dropped.
REQ-020 busy SHALL be a direct decode of state (CALC or DONE).
- No combinational path from start to busy or done.

Reset
REQ-021 When rst=1 at an edge, the block SHALL go to IDLE and clear all registers: state=IDLE, p=0, busy=0, done=0, counter=0, acc=0, mcand=0.
REQ-022 rst SHALL have priority over start and over any in-flight CALC step.
- An interrupted operation is discarded.
- done SHALL NOT be produced for an interrupted operation.
REQ-023 The first start SHALL be accepted on the first edge with rst=0 and state IDLE.

Structure
REQ-024 Shared package constants:
- operand width (4) and product width (8);
- step count (4);
- state encodings IDLE=2'd0, CALC=2'd1, DONE=2'd2.
REQ-025 The datapath adder SHALL be exactly one instance of the existing sum4b module (ports a, b, ci, co, so).
- No behavioural "+" operator is used for the partial-product sum.
REQ-026 The FSM, counter and shift register SHALL reside in mul4b_seq; no further sub-modules.

Verification
REQ-027 Maximum operands: a=4'hF, b=4'hF, start pulsed 1 cycle -> done after 4 cycles, p=8'hE1 (225), busy high for 5 cycles.
REQ-028 Carry propagation: a=4'hA, b=4'h3 -> p=8'h1E.
- a=4'h7, b=4'h9 -> p=8'h3F.
- Both cases use the same latency as REQ-027.
REQ-029 Zero operand: a=4'h0, b=4'hF -> p=8'h00, with done still pulsed once.
REQ-030 Start while busy: a=4'h3, b=4'h5 started, then a second start with a=4'hF, b=4'hF two cycles later -> single done, p=8'h0F, second request ignored.
REQ-031 Reset mid-operation: a=4'hF, b=4'hF started, rst asserted in the 2nd CALC cycle -> next cycle p=0, busy=0, done=0.
- No done pulse follows.
- A fresh a=4'h2, b=4'h3 -> p=8'h06.
REQ-032 Back-to-back: start held high with a=4'h4, b=4'h4 -> done every 6 cycles, p=8'h10 each time.
- Exhaustive sweep of all 256 operand pairs against a reference model with zero mismatches.
